// File: rtl/trivium_seq.sv
// Trivium keystream sequencer: gathers key and IV bytes, loads the core,
// runs the warm-up rounds, then produces keystream bytes for a reader.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOAD_KEY | accepting key bytes into core_key, LSB byte first
// LOAD_IV  | accepting IV bytes into core_iv, LSB byte first
// LOAD     | core_load pulse; core copies key/IV into its state
// INIT     | stepping the core through warm-up, output discarded
// GEN      | stepping the core 8 times, collecting z bits LSB first
// READY    | keystream byte on offer until the consumer reads it
module trivium_seq #(
    parameter int INIT_ROUNDS = 1152,
    parameter int KEY_BYTES   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             cfg_byte,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   restart,
    output logic [8*KEY_BYTES-1:0] core_key,
    output logic [8*KEY_BYTES-1:0] core_iv,
    output logic                   core_load,
    output logic                   core_step,
    input  logic                   core_bit,
    output logic [7:0]             ks_byte,
    output logic                   ks_valid,
    input  logic                   ks_read,
    output logic                   busy
);

    localparam logic [3:0]  LAST_IDX   = 4'(KEY_BYTES - 1);
    localparam logic [10:0] LAST_ROUND = 11'(INIT_ROUNDS - 1);

    typedef enum logic [2:0] {
        LOAD_KEY,
        LOAD_IV,
        LOAD,
        INIT,
        GEN,
        READY
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [10:0] round_cnt;
    logic [2:0]  bit_cnt;

    // Sequencer FSM; every output is a register updated alongside the state
    // so core_step is already high in the cycle the core is meant to step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_KEY;
            idx       <= '0;
            round_cnt <= '0;
            bit_cnt   <= '0;
            core_key  <= '0;
            core_iv   <= '0;
            ks_byte   <= '0;
            ks_valid  <= 1'b0;
            core_load <= 1'b0;
            core_step <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
        end else begin
            core_load <= 1'b0;
            if (restart) begin
                // Restart wins over any handshake in the same cycle.
                state     <= LOAD_KEY;
                idx       <= '0;
                ks_valid  <= 1'b0;
                core_step <= 1'b0;
                cfg_ready <= 1'b1;
                busy      <= 1'b1;
            end else begin
                case (state)
                    LOAD_KEY: begin
                        if (cfg_valid && cfg_ready) begin
                            core_key[{idx, 3'b000} +: 8] <= cfg_byte;
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                state <= LOAD_IV;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                    LOAD_IV: begin
                        if (cfg_valid && cfg_ready) begin
                            core_iv[{idx, 3'b000} +: 8] <= cfg_byte;
                            if (idx == LAST_IDX) begin
                                idx       <= '0;
                                state     <= LOAD;
                                cfg_ready <= 1'b0;
                                core_load <= 1'b1;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                    LOAD: begin
                        state     <= INIT;
                        round_cnt <= '0;
                        core_step <= 1'b1;
                    end
                    INIT: begin
                        round_cnt <= round_cnt + 11'd1;
                        if (round_cnt == LAST_ROUND) begin
                            state   <= GEN;
                            bit_cnt <= '0;
                        end
                    end
                    GEN: begin
                        ks_byte[bit_cnt] <= core_bit;
                        bit_cnt          <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state     <= READY;
                            core_step <= 1'b0;
                            ks_valid  <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                    READY: begin
                        if (ks_read) begin
                            state     <= GEN;
                            bit_cnt   <= '0;
                            core_step <= 1'b1;
                            ks_valid  <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    default: begin
                        state <= LOAD_KEY;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/trivium_seq.md
# trivium_seq

Sequencer for the Trivium keystream core. It collects an 80-bit key and 80-bit IV as a byte stream (typically from the UART receive path), loads them into the core and runs the 1152-cycle warm-up. It then steps the core eight bits at a time and presents each keystream byte to the encryption logic over a valid/read handshake. It is the only block that drives the core's load and step controls.

## Interface
- `INIT_ROUNDS`, default 1152: number of warm-up steps after load; output bits during warm-up are discarded.
- `KEY_BYTES`, default 10: number of key bytes, then the same number of IV bytes.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `cfg_byte`, in, 8: key/IV byte.
- `cfg_valid`, in, 1: `cfg_byte` is valid.
- `cfg_ready`, out, 1: sequencer accepts a config byte this cycle.
- `restart`, in, 1: single-cycle pulse; abandons the current key and returns to key loading.
- `core_key`, out, 80: key register driven to the core.
- `core_iv`, out, 80: IV register driven to the core.
- `core_load`, out, 1: one-cycle pulse; the core loads `core_key`/`core_iv` into its state.
- `core_step`, out, 1: the core advances one bit at this clock edge.
- `core_bit`, in, 1: the core's current keystream bit z, valid before the step.
- `ks_byte`, out, 8: keystream byte.
- `ks_valid`, out, 1: `ks_byte` is valid.
- `ks_read`, in, 1: consumer takes `ks_byte`.
- `busy`, out, 1: high in any state other than READY.

## Operation
- States: LOAD_KEY, LOAD_IV, LOAD, INIT, GEN, READY.
- Reset values: state=LOAD_KEY; `core_key`=0, `core_iv`=0, `ks_byte`=0; `ks_valid`=0, `core_load`=0, `core_step`=0; `cfg_ready`=1; `busy`=1.
- **LOAD_KEY**
  - `cfg_ready`=1.
  - Each handshake (`cfg_valid` & `cfg_ready`) with byte index i (0..9) writes `core_key[8i+7:8i]`.
  - After byte 9, go to LOAD_IV; the index is a 4-bit counter that resets to 0.
- **LOAD_IV**: same behaviour into `core_iv`. After byte 9, go to LOAD.
- **LOAD**
  - `cfg_ready`=0. `core_load`=1 for exactly one cycle.
  - Go to INIT with the 11-bit round counter cleared.
- **INIT**
  - `core_step`=1 every cycle; the counter increments.
  - After `INIT_ROUNDS` steps, go to GEN with the bit counter at 0.
- **GEN**
  - `core_step`=1 every cycle.
  - Step k (k=0..7) samples `core_bit` into `ks_byte[k]` (LSB first).
  - After the 8th step, go to READY.
- **READY**
  - `ks_valid`=1, `core_step`=0; `ks_byte` is held stable.
  - A cycle with `ks_read`=1 consumes the byte: `ks_valid` is 0 the next cycle and the state returns to GEN.
- `ks_read` while `ks_valid`=0 is ignored. `cfg_valid` outside LOAD_KEY/LOAD_IV is ignored; no byte is consumed.
- **restart** (any state)
  - Next cycle: state=LOAD_KEY, index 0, `ks_valid`=0, `core_step`=0.
  - Key/IV registers keep their old values until overwritten.
- `restart` has priority over a simultaneous `ks_read` or config handshake; that handshake is dropped.
- The core never receives `core_load` and `core_step` in the same cycle.

## Timing
- Cycle 0 is the cycle of the final IV handshake.
  - Cycle 1: `core_load`=1.
  - Cycles 2..1153: `core_step`=1 (warm-up).
  - Cycles 1154..1161: `core_step`=1 (sampling).
  - Cycle 1162: `ks_valid`=1 first.
- Read-to-next-valid: `ks_read` at cycle R gives steps at R+1..R+8 and `ks_valid`=1 at R+9. Steady throughput is one byte per 9 cycles with an always-reading consumer.
- All outputs are registered.
- `cfg_ready` is a pure function of state, with no combinational path from `cfg_valid`.
- Asynchronous reset mid-operation takes effect immediately: all outputs take their reset values and any partial key or byte is lost.

## Test plan
- **Reset and load**
  - Stimulus: after reset, send key bytes 0x00..0x09 then IV bytes 0x10..0x19 back-to-back.
  - Response: `core_key`=0x09080706050403020100, `core_iv`=0x19181716151413121110; `core_load` pulses exactly once, one cycle after the last IV byte.
- **Warm-up and first byte**
  - Stimulus: core model with `core_bit` toggling each step, starting at 1.
  - Response: exactly 1152 `core_step` cycles before sampling; first `ks_byte`=0x55 with `ks_valid` at cycle 1162.
- **Throughput and hold**
  - Stimulus: hold `ks_read`=1 for 3 bytes, then drop it for 20 cycles.
  - Response: 9-cycle spacing between bytes; while unread, `ks_byte` is stable and `core_step`=0.
- **Restart during INIT**
  - Stimulus: assert `restart` at warm-up step 500, then reload.
  - Response: state goes to LOAD_KEY, `cfg_ready`=1, `ks_valid` stays 0; a fresh 1152-step warm-up follows the new load.
- **Ignored inputs**
  - Stimulus: `cfg_valid`=1 during GEN/READY, and `ks_read` with `ks_valid`=0.
  - Response: no register change and no extra steps.
- **Mid-stream reset**
  - Stimulus: drive `rst_n` low for 1 cycle in READY.
  - Response: `ks_valid`=0 immediately, `core_key`=0, `cfg_ready`=1.
